uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, decoded byte and status pulses out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport slave  (input rx, output data, valid, frame_err, busy);
    modport master (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, framing-error detection and break hold.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx #(
    parameter int unsigned CLK_HZ = 24000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int unsigned PERIOD = CLK_HZ / BAUD;
    localparam int unsigned HALF   = PERIOD / 2;
    localparam int unsigned CNT_W  = 11;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned LAG    = 1;
`else
    localparam int unsigned LAG    = 0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t             state;
    logic               rx_s1;
    logic               rxs;
    logic               settle;
    logic               armed;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         idx;
    logic [7:0]         shift;
    logic [7:0]         data_r;
    logic               valid_r;
    logic               frame_err_r;
    logic               busy_r;
    logic               smp;

    // Input synchronizer, preset to the idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= bus.rx;
            rxs   <= rx_s1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d1;
    logic rxs_d2;

    // Two-cycle history so the vote is taken one cycle after the nominal sample point
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxs_d1 <= 1'b1;
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d1 <= rxs;
            rxs_d2 <= rxs_d1;
        end
    end

    assign smp = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
    assign smp = rxs;
`endif

    // Receive FSM; armed blocks a start until the real line has been seen high after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            settle      <= 1'b0;
            armed       <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            settle      <= 1'b1;
            if (settle && rx_s1) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state  <= START;
                        cnt    <= CNT_W'(HALF - 1 + LAG);
                        busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!smp) begin
                        state <= DATA;
                        cnt   <= CNT_W'(PERIOD - 1);
                        idx   <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shift <= {smp, shift[7:1]};
                        cnt   <= CNT_W'(PERIOD - 1);
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (smp) begin
                        data_r  <= shift;
                        valid_r <= 1'b1;
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        frame_err_r <= 1'b1;
                        state       <= BREAK;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a frame-level timing/data model.
module tb_uart_rx;
    localparam int unsigned CLK_HZ = 24000000;
    localparam int unsigned BAUD   = 115200;
    localparam int P = int'(CLK_HZ / BAUD);
    localparam int H = P / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int LAG = 0;
    localparam logic [7:0] GLITCH_EXP = 8'hFF;
`endif
    // Pulse cycle relative to the cycle rx was driven low: one edge to reach the first
    // synchronizer flop, then 2 + HALF + 9*PERIOD cycles to the stop-bit decision.
    localparam int LAT = 1 + 2 + H + 9 * P + LAG;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   both_cnt = 0;
    int   vq_cyc[$];
    logic [7:0] vq_data[$];
    int   fq_cyc[$];
    logic [7:0] exp_data;

    uart_rx_if bus();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (bus.valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(bus.data);
        end
        if (bus.frame_err) fq_cyc.push_back(cyc);
        if (bus.valid && bus.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        bus.rx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                              output int fall);
        fall = cyc;
        hold(1'b0, P);
        for (int i = 0; i < 8; i++) hold(b[i], P);
        hold(stop, stop_len);
    endtask

    task automatic clear_q();
        vq_cyc.delete();
        vq_data.delete();
        fq_cyc.delete();
    endtask

    // Frame-level reference: good stop -> one valid with the byte; bad stop -> one frame_err, data held
    task automatic check_frame(input string tag, input int fall, input logic [7:0] b, input logic good);
        if (good) begin
            check({tag, "_nvalid"}, 32'(vq_cyc.size()), 32'd1);
            if (vq_cyc.size() > 0) begin
                check({tag, "_vcyc"}, 32'(vq_cyc[0]), 32'(fall + LAT));
                check({tag, "_data"}, 32'(vq_data[0]), 32'(b));
            end
            check({tag, "_nferr"}, 32'(fq_cyc.size()), 32'd0);
            exp_data = b;
        end else begin
            check({tag, "_nferr"}, 32'(fq_cyc.size()), 32'd1);
            if (fq_cyc.size() > 0) check({tag, "_fcyc"}, 32'(fq_cyc[0]), 32'(fall + LAT));
            check({tag, "_nvalid"}, 32'(vq_cyc.size()), 32'd0);
            check({tag, "_held"}, 32'(bus.data), 32'(exp_data));
        end
        clear_q();
    endtask

    initial begin
        int fall;
        int fall2;
        logic [7:0] b;
        logic [7:0] b81;
        logic stop;
        int gap;

        bus.rx   = 1'b1;
        reset    = 1'b0;
        exp_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        hold(1'b1, 20);

        send_frame(8'hA5, 1'b1, P, fall);
        check_frame("a5", fall, 8'hA5, 1'b1);
        check("a5_busy", 32'(bus.busy), 32'd0);
        hold(1'b1, 10);

        // Short low pulse is rejected at the start-bit centre
        fall = cyc;
        hold(1'b0, 50);
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        hold(1'b1, 60);
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        hold(1'b1, 100);
        check("glitch_nvalid", 32'(vq_cyc.size()), 32'd0);
        check("glitch_nferr", 32'(fq_cyc.size()), 32'd0);
        clear_q();

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, P + 500, fall);
        check("brk_busy_hi", 32'(bus.busy), 32'd1);
        check_frame("brk", fall, 8'h3C, 1'b0);
        hold(1'b1, 5);
        check("brk_busy_lo", 32'(bus.busy), 32'd0);
        hold(1'b1, 20);

        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40));
            send_frame(b, stop, P, fall);
            check_frame($sformatf("rnd%0d", n), fall, b, stop);
            hold(1'b1, gap);
        end
        hold(1'b1, 20);

        // Back-to-back frames with no idle time between stop and start
        send_frame(8'h00, 1'b1, P, fall);
        check_frame("b2b0", fall, 8'h00, 1'b1);
        send_frame(8'hFF, 1'b1, P, fall2);
        check_frame("b2b1", fall2, 8'hFF, 1'b1);
        hold(1'b1, 50);

        // Reset during bit 4 of 0x81, with the line still low at release
        b81 = 8'h81;
        hold(1'b0, P);
        for (int i = 0; i < 4; i++) hold(b81[i], P);
        hold(1'b0, H);
        check("mid_busy_hi", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(bus.data), 32'h00);
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        exp_data = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        hold(1'b0, 300);
        check("rel_low_busy", 32'(bus.busy), 32'd0);
        check("rel_low_nvalid", 32'(vq_cyc.size()), 32'd0);
        check("rel_low_nferr", 32'(fq_cyc.size()), 32'd0);
        clear_q();
        hold(1'b1, 30);
        send_frame(8'h55, 1'b1, P, fall);
        check_frame("post_rst", fall, 8'h55, 1'b1);
        hold(1'b1, 20);

        // One-cycle high glitch at the centre of every data bit of 0x00
        fall = cyc;
        hold(1'b0, P);
        for (int i = 0; i < 8; i++) begin
            hold(1'b0, H);
            hold(1'b1, 1);
            hold(1'b0, P - H - 1);
        end
        hold(1'b1, P);
        check_frame("ctr_glitch", fall, GLITCH_EXP, 1'b1);
        hold(1'b1, 20);

        check("no_overlap", 32'(both_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
